// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: owns HI/LO, runs mult/div
// for a fixed number of busy cycles and handles mthi/mtlo writes when idle.
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       E_Start,
   input  logic             E_Signed,
   input  logic [WIDTH-1:0] E_A,
   input  logic [WIDTH-1:0] E_B,
   input  logic [1:0]       E_HiLoWe,
   output logic             E_Busy,
   output logic [WIDTH-1:0] E_HI,
   output logic [WIDTH-1:0] E_LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               sgn_q, sgn_d;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] divres;

   // Full-width product; sign-extending both operands makes the low 2*WIDTH
   // bits of the unsigned product equal to the signed product.
   function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic             sgn);
      logic [2*WIDTH-1:0] ea;
      logic [2*WIDTH-1:0] eb;
      ea = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      eb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
      return ea * eb;
   endfunction

   // Returns {remainder, quotient}. Signed division works on magnitudes, then
   // the quotient is negated when signs differ and the remainder follows the
   // dividend. MIN / -1 wraps back to MIN with remainder 0.
   function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic             sgn);
      logic             neg_a;
      logic             neg_b;
      logic [WIDTH-1:0] ma;
      logic [WIDTH-1:0] mb;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      neg_a = sgn & a[WIDTH-1];
      neg_b = sgn & b[WIDTH-1];
      ma    = neg_a ? (~a + 1'b1) : a;
      mb    = neg_b ? (~b + 1'b1) : b;
      if (mb == '0) begin
         q = '0;
         r = '0;
      end else begin
         q = ma / mb;
         r = ma % mb;
      end
      if (neg_a ^ neg_b) q = ~q + 1'b1;
      if (neg_a)         r = ~r + 1'b1;
      return {r, q};
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      prod    = mul_full(a_q, b_q, sgn_q);
      divres  = div_full(a_q, b_q, sgn_q);

      case (state_q)
         IDLE: begin
            if (E_Start == 2'b01 || E_Start == 2'b10) begin
               // A valid start takes priority over any same-cycle mthi/mtlo.
               a_d     = E_A;
               b_d     = E_B;
               sgn_d   = E_Signed;
               state_d = (E_Start == 2'b01) ? MUL : DIV;
               cnt_d   = (E_Start == 2'b01) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else begin
               if (E_HiLoWe[1]) hi_d = E_A;
               if (E_HiLoWe[0]) lo_d = E_A;
            end
         end
         MUL: begin
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = prod[2*WIDTH-1:WIDTH];
               lo_d    = prod[WIDTH-1:0];
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DIV: begin
            if (cnt_q == CNT_W'(1)) begin
               // Divide by zero runs the full latency but leaves HI/LO alone.
               if (b_q != '0) begin
                  hi_d = divres[2*WIDTH-1:WIDTH];
                  lo_d = divres[WIDTH-1:0];
               end
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Operand latches only matter while busy, so they carry no reset.
   always_ff @(posedge clk) begin
      a_q   <= a_d;
      b_q   <= b_d;
      sgn_q <= sgn_d;
   end

   assign E_Busy = busy_q;
   assign E_HI   = hi_q;
   assign E_LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed and randomized bench for md_unit with a plain-arithmetic HI/LO model.
module tb_md_unit;

   logic        clk;
   logic        reset_n;
   logic [1:0]  E_Start;
   logic        E_Signed;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic [1:0]  E_HiLoWe;
   logic        E_Busy;
   logic [31:0] E_HI;
   logic [31:0] E_LO;

   int tests;
   int fails;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset_n(reset_n), .E_Start(E_Start), .E_Signed(E_Signed),
      .E_A(E_A), .E_B(E_B), .E_HiLoWe(E_HiLoWe), .E_Busy(E_Busy),
      .E_HI(E_HI), .E_LO(E_LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_op(input logic [1:0] st, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p;
      if (st == 2'b01) begin
         if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
         end else begin
            p = 64'(a) * 64'(b);
         end
         m_hi = p[63:32];
         m_lo = p[31:0];
      end else if (b != 32'd0) begin
         if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
         end else begin
            m_lo = a / b;
            m_hi = a % b;
         end
      end
   endtask

   task automatic set_hilo(input logic [1:0] we, input logic [31:0] data);
      @(negedge clk);
      E_HiLoWe = we;
      E_A      = data;
      @(negedge clk);
      E_HiLoWe = 2'b00;
      E_A      = $urandom;
      if (we[1]) m_hi = data;
      if (we[0]) m_lo = data;
      check("mthi_hi", E_HI, m_hi);
      check("mtlo_lo", E_LO, m_lo);
   endtask

   // Issue an op, optionally intrude with a start+mthi/mtlo while busy, then
   // count busy cycles and compare HI/LO against the model.
   task automatic run_op(input string tag, input logic [1:0] st, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] we, input bit intrude);
      int n;
      int want;
      want = (st == 2'b01) ? 5 : 10;
      @(negedge clk);
      E_Start  = st;
      E_Signed = sgn;
      E_A      = a;
      E_B      = b;
      E_HiLoWe = we;
      @(negedge clk);
      E_Start  = 2'b00;
      E_HiLoWe = 2'b00;
      E_Signed = $urandom_range(0, 1);
      E_A      = $urandom;
      E_B      = $urandom;
      n = 0;
      if (intrude) begin
         if (E_Busy) n++;
         E_Start  = 2'b10;
         E_HiLoWe = 2'b11;
         E_A      = 32'h0000DEAD;
         @(negedge clk);
         E_Start  = 2'b00;
         E_HiLoWe = 2'b00;
      end
      while (E_Busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      model_op(st, sgn, a, b);
      check({tag, "_busy"}, 32'(n), 32'(want));
      check({tag, "_hi"}, E_HI, m_hi);
      check({tag, "_lo"}, E_LO, m_lo);
   endtask

   initial begin
      logic [1:0]  st;
      logic [31:0] ra, rb;
      tests    = 0;
      fails    = 0;
      m_hi     = 32'd0;
      m_lo     = 32'd0;
      reset_n  = 1'b0;
      E_Start  = 2'b00;
      E_Signed = 1'b0;
      E_A      = 32'd0;
      E_B      = 32'd0;
      E_HiLoWe = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(E_Busy), 32'd0);
      check("rst_hi", E_HI, 32'd0);
      check("rst_lo", E_LO, 32'd0);
      reset_n = 1'b1;

      // Reset in the middle of a multiply aborts it with no late write.
      set_hilo(2'b11, 32'h00000055);
      @(negedge clk);
      E_Start = 2'b01; E_Signed = 1'b0; E_A = 32'd1000; E_B = 32'd1000;
      @(negedge clk);
      E_Start = 2'b00;
      check("abort_busy_before", 32'(E_Busy), 32'd1);
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("abort_busy_now", 32'(E_Busy), 32'd0);
      check("abort_hi_now", E_HI, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      check("abort_busy_after", 32'(E_Busy), 32'd0);
      check("abort_hi_after", E_HI, 32'd0);
      check("abort_lo_after", E_LO, 32'd0);

      run_op("mul_s", 2'b01, 1'b1, 32'hFFFFFFFE, 32'd3, 2'b00, 1'b0);
      check("mul_s_hi_lit", E_HI, 32'hFFFFFFFF);
      check("mul_s_lo_lit", E_LO, 32'hFFFFFFFA);
      run_op("mul_u", 2'b01, 1'b0, 32'hFFFFFFFF, 32'd2, 2'b00, 1'b0);
      check("mul_u_hi_lit", E_HI, 32'h00000001);
      check("mul_u_lo_lit", E_LO, 32'hFFFFFFFE);
      run_op("div_s", 2'b10, 1'b1, 32'hFFFFFFF9, 32'd2, 2'b00, 1'b0);
      check("div_s_lo_lit", E_LO, 32'hFFFFFFFD);
      check("div_s_hi_lit", E_HI, 32'hFFFFFFFF);
      run_op("div_u", 2'b10, 1'b0, 32'd100, 32'd7, 2'b00, 1'b0);
      check("div_u_lo_lit", E_LO, 32'd14);
      check("div_u_hi_lit", E_HI, 32'd2);

      set_hilo(2'b10, 32'h00000011);
      set_hilo(2'b01, 32'h00000022);
      run_op("div0", 2'b10, 1'b1, 32'h12345678, 32'd0, 2'b00, 1'b0);
      check("div0_hi_lit", E_HI, 32'h00000011);
      check("div0_lo_lit", E_LO, 32'h00000022);
      run_op("div_ovf", 2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, 2'b00, 1'b0);
      check("div_ovf_lo_lit", E_LO, 32'h80000000);
      check("div_ovf_hi_lit", E_HI, 32'h00000000);

      // Start and mthi/mtlo while busy are ignored; then a start beats a same-cycle mtlo.
      run_op("intrude", 2'b01, 1'b0, 32'h00010001, 32'h00020003, 2'b00, 1'b1);
      run_op("start_wins", 2'b01, 1'b0, 32'h00001234, 32'h00000010, 2'b01, 1'b0);
      check("start_wins_lo_lit", E_LO, 32'h00012340);

      // E_Start=11 is ignored and lets mthi/mtlo through.
      @(negedge clk);
      E_Start = 2'b11; E_HiLoWe = 2'b11; E_A = 32'hCAFEF00D;
      @(negedge clk);
      E_Start = 2'b00; E_HiLoWe = 2'b00;
      m_hi = 32'hCAFEF00D;
      m_lo = 32'hCAFEF00D;
      check("st11_busy", 32'(E_Busy), 32'd0);
      check("st11_hi", E_HI, m_hi);
      check("st11_lo", E_LO, m_lo);

      for (int i = 0; i < 30; i++) begin
         st = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'hFFFFFFFF;
            2: ra = 32'h80000000;
            3: rb = 32'(($urandom_range(1, 15)));
            default: ;
         endcase
         if ($urandom_range(0, 4) == 0) set_hilo(2'($urandom_range(1, 3)), $urandom);
         run_op("rand", st, 1'($urandom_range(0, 1)), ra, rb, 2'b00, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
